// File: rtl/sad_search_ctrl.sv
// Full-search SAD sequencer: issues every candidate index of the window in order,
// collects the in-order SAD results and keeps the minimum with its decoded x/y position.
module sad_search_ctrl #(
    parameter int WIN_X = 64,
    parameter int WIN_Y = 64,
    parameter int SAD_W = 16
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Start,
    input  logic              Stall,
    output logic              CandValid,
    output logic [31:0]       CandIndex,
    input  logic              SadValid,
    input  logic [SAD_W-1:0]  SadIn,
    output logic              Busy,
    output logic              Done,
    output logic [SAD_W-1:0]  BestSad,
    output logic [31:0]       BestIndex,
    output logic [31:0]       BestX,
    output logic [31:0]       BestY
);

    // state | meaning
    // IDLE  | waiting for Start, Best* hold the last search result
    // ISSUE | one candidate per non-stalled cycle, results collected
    // DRAIN | all candidates issued, waiting for outstanding results
    // DONE  | one-cycle Done pulse, then back to IDLE
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    localparam logic [31:0] N      = 32'(WIN_X * WIN_Y);
    localparam int          LOG_WY = $clog2(WIN_Y);

    state_t      state;
    logic [31:0] issue_cnt;
    logic [31:0] ret_cnt;
    logic        accept;
    logic        take_best;
    logic        ret_done;

    // Results beyond the N-th are dropped so a stray SadValid cannot disturb Best*.
    assign accept    = SadValid && (ret_cnt != N) && ((state == ISSUE) || (state == DRAIN));
    assign take_best = accept && ((ret_cnt == 32'd0) || (SadIn < BestSad));
    assign ret_done  = (ret_cnt == N) || (accept && (ret_cnt == N - 32'd1));

    assign BestX = BestIndex >> LOG_WY;
    assign BestY = BestIndex & 32'(WIN_Y - 1);

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state     <= IDLE;
            issue_cnt <= '0;
            ret_cnt   <= '0;
            CandValid <= 1'b0;
            CandIndex <= '0;
            Busy      <= 1'b0;
            Done      <= 1'b0;
            BestSad   <= '1;
            BestIndex <= '0;
        end else begin
            if (take_best) begin
                BestSad   <= SadIn;
                BestIndex <= ret_cnt;
            end
            if (accept) begin
                ret_cnt <= ret_cnt + 32'd1;
            end

            case (state)
                IDLE: begin
                    CandValid <= 1'b0;
                    Done      <= 1'b0;
                    if (Start) begin
                        state     <= ISSUE;
                        Busy      <= 1'b1;
                        issue_cnt <= '0;
                        ret_cnt   <= '0;
                        BestSad   <= '1;
                        BestIndex <= '0;
                    end
                end
                ISSUE: begin
                    if (!Stall) begin
                        CandValid <= 1'b1;
                        CandIndex <= issue_cnt;
                        issue_cnt <= issue_cnt + 32'd1;
                        if (issue_cnt == N - 32'd1) begin
                            if (ret_done) begin
                                state <= DONE;
                                Done  <= 1'b1;
                                Busy  <= 1'b0;
                            end else begin
                                state <= DRAIN;
                            end
                        end
                    end else begin
                        CandValid <= 1'b0;
                    end
                end
                DRAIN: begin
                    CandValid <= 1'b0;
                    if (ret_done) begin
                        state <= DONE;
                        Done  <= 1'b1;
                        Busy  <= 1'b0;
                    end
                end
                DONE: begin
                    CandValid <= 1'b0;
                    Done      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sad_search_ctrl.sv
// Bench for sad_search_ctrl: a latency-2 SAD datapath model feeds results back while a
// monitor checks each Done against expected results queued when the search is launched.
module tb_sad_search_ctrl;

    localparam int N = 4096;
    localparam int L = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        stall;
    logic        cand_valid;
    logic [31:0] cand_index;
    logic        sad_valid;
    logic [15:0] sad_in;
    logic        busy;
    logic        done;
    logic [15:0] best_sad;
    logic [31:0] best_index;
    logic [31:0] best_x;
    logic [31:0] best_y;

    sad_search_ctrl #(.WIN_X(64), .WIN_Y(64), .SAD_W(16)) dut (
        .Clk(clk), .Rst(rst_n), .Start(start), .Stall(stall),
        .CandValid(cand_valid), .CandIndex(cand_index),
        .SadValid(sad_valid), .SadIn(sad_in),
        .Busy(busy), .Done(done), .BestSad(best_sad), .BestIndex(best_index),
        .BestX(best_x), .BestY(best_y)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] sad;
        logic [31:0] idx;
        logic [31:0] x;
        logic [31:0] y;
        int          lat;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   start_cyc = 0;
    int   done_count = 0;
    int   mode = 0;
    logic stall_en = 1'b0;
    logic extra_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [15:0] sad_of(input logic [31:0] idx);
        case (mode)
            0: sad_of = (idx == 32'd1234) ? 16'd5 : 16'd1000;
            1: sad_of = (idx == 32'd300 || idx == 32'd200) ? 16'd7 : 16'd50;
            2: sad_of = 16'hFFFF;
            default: sad_of = 16'(32'd4095 - idx);
        endcase
    endfunction

    // datapath model, stall injection and post-completion stray results
    initial begin
        logic        pipe_v[L];
        logic [15:0] pipe_s[L];
        logic        sv;
        logic [15:0] ss;
        logic        busy_d;
        int          rcount;
        int          extra_left;
        int          stall_left;
        for (int i = 0; i < L; i++) begin
            pipe_v[i] = 1'b0;
            pipe_s[i] = '0;
        end
        busy_d = 1'b0; rcount = 0; extra_left = 0; stall_left = 0;
        forever begin
            @(negedge clk);
            if (busy && !busy_d) rcount = 0;
            busy_d = busy;
            sv = pipe_v[L-1];
            ss = pipe_s[L-1];
            for (int i = L - 1; i > 0; i--) begin
                pipe_v[i] = pipe_v[i-1];
                pipe_s[i] = pipe_s[i-1];
            end
            pipe_v[0] = cand_valid;
            pipe_s[0] = sad_of(cand_index);
            if (sv) rcount++;
            if (extra_left > 0) begin
                sad_valid = 1'b1;
                sad_in    = 16'd0;
                extra_left--;
            end else begin
                sad_valid = sv;
                sad_in    = ss;
                if (sv && rcount == N && extra_en) begin
                    extra_left = 3;
                    extra_en   = 1'b0;
                end
            end
            if (stall_left > 0) begin
                check("stall_valid", 32'(cand_valid), 32'd0);
                check("stall_hold", cand_index, 32'd499);
                stall_left--;
                if (stall_left == 0) stall = 1'b0;
            end else if (stall_en && cand_valid && cand_index == 32'd499) begin
                stall      = 1'b1;
                stall_left = 10;
                stall_en   = 1'b0;
            end
        end
    end

    // monitor / scoreboard
    initial begin
        logic        mb;
        logic        done_prev;
        logic        order_err;
        logic [31:0] next_idx;
        exp_t        e;
        mb = 1'b0; done_prev = 1'b0; order_err = 1'b0; next_idx = '0;
        forever begin
            @(negedge clk);
            if (busy && !mb) begin
                next_idx  = '0;
                order_err = 1'b0;
            end
            mb = busy;
            if (cand_valid) begin
                if (cand_index != next_idx) order_err = 1'b1;
                next_idx++;
            end
            if (done) begin
                done_count++;
                check("done_pulse", 32'(done_prev), 32'd0);
                check("busy_at_done", 32'(busy), 32'd0);
                if (q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    check("best_sad", 32'(best_sad), 32'(e.sad));
                    check("best_index", best_index, e.idx);
                    check("best_x", best_x, e.x);
                    check("best_y", best_y, e.y);
                    check("done_latency", 32'(cyc - start_cyc), 32'(e.lat));
                    check("issue_order", 32'(order_err), 32'd0);
                    check("issue_count", next_idx, 32'(N));
                end
            end
            done_prev = done;
        end
    end

    task automatic run_search(input int m, input logic st, input logic ex, input logic pulse_busy,
                              input logic [15:0] sad, input logic [31:0] idx,
                              input logic [31:0] x, input logic [31:0] y, input int lat);
        exp_t e;
        int   d0;
        int   t;
        mode = m; stall_en = st; extra_en = ex;
        e.sad = sad; e.idx = idx; e.x = x; e.y = y; e.lat = lat;
        q.push_back(e);
        d0 = done_count;
        @(negedge clk);
        start_cyc = cyc + 1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("init_sad", 32'(best_sad), 32'hFFFF);
        check("init_index", best_index, 32'd0);
        t = 0;
        while (done_count == d0 && t < 6000) begin
            @(negedge clk);
            t++;
            if (pulse_busy && t == 50) start = 1'b1;
            if (t == 51) start = 1'b0;
        end
        if (done_count == d0) check("done_timeout", 32'd0, 32'd1);
        repeat (3) @(negedge clk);
        check("single_done", 32'(done_count - d0), 32'd1);
    endtask

    initial begin
        int t;
        rst_n = 1'b0; start = 1'b0; stall = 1'b0; sad_valid = 1'b0; sad_in = '0;
        repeat (3) @(negedge clk);
        check("rst_cand_valid", 32'(cand_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_best_sad", 32'(best_sad), 32'hFFFF);
        rst_n = 1'b1;

        // abort a search at index 100 with reset
        mode = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t = 0;
        while (!(cand_valid && cand_index == 32'd100) && t < 500) begin
            @(negedge clk);
            t++;
        end
        check("reach_idx100", cand_index, 32'd100);
        rst_n = 1'b0;
        #1;
        check("abort_cand_valid", 32'(cand_valid), 32'd0);
        check("abort_cand_index", cand_index, 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_best_sad", 32'(best_sad), 32'hFFFF);
        check("abort_best_index", best_index, 32'd0);
        check("abort_best_x", best_x, 32'd0);
        check("abort_best_y", best_y, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("abort_no_done", 32'(done_count), 32'd0);
        check("abort_idle", 32'(busy), 32'd0);

        run_search(0, 1'b0, 1'b0, 1'b0, 16'd5, 32'd1234, 32'd19, 32'd18, N + L + 1);
        run_search(1, 1'b0, 1'b0, 1'b0, 16'd7, 32'd200, 32'd3, 32'd8, N + L + 1);
        run_search(0, 1'b1, 1'b0, 1'b0, 16'd5, 32'd1234, 32'd19, 32'd18, N + L + 11);
        run_search(2, 1'b0, 1'b0, 1'b0, 16'hFFFF, 32'd0, 32'd0, 32'd0, N + L + 1);
        run_search(3, 1'b0, 1'b1, 1'b1, 16'd0, 32'd4095, 32'd63, 32'd63, N + L + 1);
        repeat (3) @(negedge clk);
        check("hold_sad", 32'(best_sad), 32'd0);
        check("hold_index", best_index, 32'd4095);
        run_search(1, 1'b0, 1'b0, 1'b0, 16'd7, 32'd200, 32'd3, 32'd8, N + L + 1);
        check("queue_empty", 32'(q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sad_search_ctrl.md
Name: sad_search_ctrl

Overview:
- Sequences the full-search SAD datapath over a WIN_X x WIN_Y candidate window.
- Issues one candidate index per cycle, collects the returned SAD values in order, and tracks the minimum.
- Reports the best SAD, its linear index, and its decoded x/y coordinates.
- Index encoding: index = x*WIN_Y + y, so x = index >> log2(WIN_Y) and y = index & (WIN_Y-1). This is the same split used by the coordinate decode in the motion-estimation path.

Parameters:
- WIN_X, 64, candidate columns; power of 2, 2..256.
- WIN_Y, 64, candidate rows; power of 2, 2..256.
- SAD_W, 16, SAD value width.

Ports:
- Clk  input  1  rising-edge clock.
- Rst  input  1  asynchronous reset, active-low (0 = reset).
- Start  input  1  single-cycle request to begin a search; sampled only in IDLE.
- Stall  input  1  datapath back-pressure; 1 = do not issue this cycle.
- CandValid  output  1  CandIndex is valid this cycle.
- CandIndex  output  32  candidate linear index to the SAD datapath.
- SadValid  input  1  SadIn is valid; results return in issue order, any latency >= 1.
- SadIn  input  SAD_W  SAD of the next outstanding candidate.
- Busy  output  1  high from the cycle after Start is accepted until the cycle Done is asserted.
- Done  output  1  one-cycle pulse when the search completes.
- BestSad  output  SAD_W  minimum SAD so far.
- BestIndex  output  32  index of BestSad.
- BestX  output  32  BestIndex >> log2(WIN_Y).
- BestY  output  32  BestIndex & (WIN_Y-1).

Behaviour:
- N = WIN_X*WIN_Y candidates per search. Issue counter and return counter are each 32 bits.
- Reset values (asynchronous on Rst=0):
  - state = IDLE, all counters 0.
  - CandValid = 0, CandIndex = 0, Busy = 0, Done = 0.
  - BestSad = all ones, BestIndex = BestX = BestY = 0.
- IDLE:
  - Start=1 -> go to ISSUE next cycle.
  - On entry to ISSUE: counters cleared, BestSad = all ones, BestIndex = 0.
  - SadValid in IDLE is ignored.
- ISSUE:
  - Stall=0 -> CandValid=1 with CandIndex = issue counter (registered outputs); issue counter increments.
  - Stall=1 -> CandValid=0; CandIndex holds its last value; the counter does not advance.
  - After index N-1 is issued -> go to DRAIN.
- DRAIN:
  - CandValid=0. Wait for outstanding results.
  - When the return counter reaches N -> go to DONE.
- Result handling (ISSUE and DRAIN):
  - Each SadValid=1 increments the return counter.
  - If SadIn < BestSad (strict, unsigned), or this is the first result of the search: BestSad <= SadIn and BestIndex <= return counter value before the increment.
  - Ties keep the earlier (lower) index.
  - BestX/BestY are combinational from BestIndex.
- DONE:
  - Done=1 for exactly one cycle, Busy=0, then go to IDLE.
  - Best* outputs hold until the next accepted Start.
- Simultaneous events:
  - Issue and return in the same cycle are both processed.
  - If the final result (return counter N-1) arrives in the same cycle as the last issue, go directly to DONE.
- Error and edge cases:
  - Start while Busy is ignored.
  - SadValid when the return counter already equals N is ignored; it must not alter Best*.
- Reset mid-search aborts immediately to the reset values. No Done is generated.
- Minimum latency, no Stall, datapath latency L: Done asserts N+L+1 cycles after the Start cycle.

Test Plan:
- Reset: Rst=0 mid-ISSUE at index 100 -> all outputs at reset values the same cycle; after Rst=1 the block idles with no Done.
- Basic min search: WIN_X=WIN_Y=64, L=2, SAD = 1000 except index 1234 = 5 -> Done once, BestSad=5, BestIndex=1234, BestX=19, BestY=18, Done 4099 cycles after Start.
- Tie: SAD=7 at indices 300 and 200, all others 50 -> BestIndex=200, BestX=3, BestY=8.
- Stall: Stall=1 for 10 cycles at index 500 -> CandIndex holds 499, CandValid=0; indices 0..4095 each issued exactly once; Done delayed by 10 cycles.
- First result all-ones: every SAD = 0xFFFF -> BestSad=0xFFFF, BestIndex=0.
- Protocol: Start pulsed during Busy -> ignored; extra SadValid after the Nth result -> Best* unchanged; second Start after Done -> Best* re-initialised and a new search runs.
